// File: rtl/ahb_mtx_input_stage.sv
// Per-master input stage of the AHB bus matrix: presents one master's address phase to the
// decoders and output stages, holds it while no output stage takes it, and returns the slave response.
//
// state      | meaning
// ADDR_LIVE  | nothing held; the master's live address/control is presented
// ADDR_HELD  | a blocked transfer is presented from the hold registers; master is stalled
module ahb_mtx_input_stage #(
    parameter int ADDR_WIDTH = 32,
    parameter int PROT_WIDTH = 4
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSELS,
    input  logic [ADDR_WIDTH-1:0] HADDRS,
    input  logic [1:0]            HTRANSS,
    input  logic                  HWRITES,
    input  logic [2:0]            HSIZES,
    input  logic [2:0]            HBURSTS,
    input  logic [PROT_WIDTH-1:0] HPROTS,
    input  logic                  HMASTLOCKS,
    input  logic                  HREADYS,
    output logic                  HREADYOUTS,
    output logic                  HRESPS,
    output logic                  sel_in,
    output logic [ADDR_WIDTH-1:0] addr_in,
    output logic [1:0]            trans_in,
    output logic                  write_in,
    output logic [2:0]            size_in,
    output logic [2:0]            burst_in,
    output logic [PROT_WIDTH-1:0] prot_in,
    output logic                  master_lock_in,
    input  logic                  active_in,
    input  logic                  readyout_in,
    input  logic                  resp_in
);

    typedef enum logic {
        ADDR_LIVE = 1'b0,
        ADDR_HELD = 1'b1
    } addr_state_t;

    addr_state_t           addr_state;
    logic                  pend;
    logic                  dphase;
    logic                  valid_live;
    logic                  accept;

    logic [ADDR_WIDTH-1:0] hold_addr;
    logic [1:0]            hold_trans;
    logic                  hold_write;
    logic [2:0]            hold_size;
    logic [2:0]            hold_burst;
    logic [PROT_WIDTH-1:0] hold_prot;
    logic                  hold_lock;

    assign pend = (addr_state == ADDR_HELD);

    always_comb begin
        // IDLE and BUSY never reach the output stages
        valid_live = HSELS & HREADYS & HTRANSS[1];

        if (pend) begin
            sel_in         = 1'b1;
            addr_in        = hold_addr;
            trans_in       = hold_trans;
            write_in       = hold_write;
            size_in        = hold_size;
            burst_in       = hold_burst;
            prot_in        = hold_prot;
            master_lock_in = hold_lock;
        end else begin
            sel_in         = valid_live;
            addr_in        = HADDRS;
            trans_in       = HTRANSS;
            write_in       = HWRITES;
            size_in        = HSIZES;
            burst_in       = HBURSTS;
            prot_in        = HPROTS;
            master_lock_in = HMASTLOCKS;
        end

        accept     = active_in & readyout_in & sel_in;
        HREADYOUTS = pend ? 1'b0 : (dphase ? readyout_in : 1'b1);
        HRESPS     = dphase & resp_in;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_state <= ADDR_LIVE;
            dphase     <= 1'b0;
            hold_addr  <= '0;
            hold_trans <= '0;
            hold_write <= 1'b0;
            hold_size  <= '0;
            hold_burst <= '0;
            hold_prot  <= '0;
            hold_lock  <= 1'b0;
        end else begin
            // with HREADYS low and nothing held, the master's address phase is not live yet
            if (pend || HREADYS) begin
                addr_state <= (sel_in && !accept) ? ADDR_HELD : ADDR_LIVE;
            end

            if (!pend && valid_live) begin
                hold_addr  <= HADDRS;
                hold_trans <= HTRANSS;
                hold_write <= HWRITES;
                hold_size  <= HSIZES;
                hold_burst <= HBURSTS;
                hold_prot  <= HPROTS;
                hold_lock  <= HMASTLOCKS;
            end

            if (readyout_in) begin
                dphase <= active_in & sel_in;
            end
        end
    end

endmodule

// File: tb/tb_ahb_mtx_input_stage.sv
// Bench for ahb_mtx_input_stage: a random AHB master and slave path around the stage, with
// transfer-order and response scoreboards, followed by short directed sequences.
module tb_ahb_mtx_input_stage;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSELS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic [2:0]  HBURSTS;
    logic [3:0]  HPROTS;
    logic        HMASTLOCKS;
    logic        HREADYS;
    logic        HREADYOUTS;
    logic        HRESPS;
    logic        sel_in;
    logic [31:0] addr_in;
    logic [1:0]  trans_in;
    logic        write_in;
    logic [2:0]  size_in;
    logic [2:0]  burst_in;
    logic [3:0]  prot_in;
    logic        master_lock_in;
    logic        active_in;
    logic        readyout_in;
    logic        resp_in;

    // single master on this port: its bus HREADY is what the stage returns
    assign HREADYS = HREADYOUTS;

    ahb_mtx_input_stage #(.ADDR_WIDTH(32), .PROT_WIDTH(4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS),
        .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS),
        .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
        .sel_in(sel_in), .addr_in(addr_in), .trans_in(trans_in), .write_in(write_in),
        .size_in(size_in), .burst_in(burst_in), .prot_in(prot_in),
        .master_lock_in(master_lock_in), .active_in(active_in), .readyout_in(readyout_in),
        .resp_in(resp_in)
    );

    always #5 HCLK = ~HCLK;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic        lock;
    } xfer_t;

    int    checks = 0;
    int    errors = 0;
    xfer_t exp_q[$];
    logic  resp_q[$];

    xfer_t cur;
    logic  cur_sel;
    int    beats_left;
    logic [31:0] next_addr;
    logic  m_dvalid;
    logic  gen_idle;
    logic  force_active;
    logic  model_on;

    logic  sl_busy;
    logic  sl_err;
    int    sl_left;
    logic  exp_err_low;

    logic  s_acc, s_rdy, s_hready;
    int    stall;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    function automatic xfer_t presented();
        xfer_t p;
        p = '{addr: addr_in, trans: trans_in, write: write_in, size: size_in,
              burst: burst_in, prot: prot_in, lock: master_lock_in};
        return p;
    endfunction

    // next master address phase: singles, INCR4 bursts with optional BUSY, idles
    task automatic gen_next();
        int r;
        cur.write = 1'($urandom);
        cur.size  = 3'($urandom_range(0, 2));
        cur.prot  = 4'($urandom);
        cur.lock  = ($urandom % 8) == 0;
        if (gen_idle) begin
            cur_sel = 1'b1; cur.trans = 2'd0; cur.burst = 3'd0; beats_left = 0;
        end else if (beats_left > 0) begin
            cur.burst = 3'd3;
            cur.addr  = next_addr;
            if ($urandom % 5 == 0) begin
                cur.trans = 2'd1;
            end else begin
                cur.trans  = 2'd3;
                next_addr  = next_addr + 32'd4;
                beats_left = beats_left - 1;
            end
        end else begin
            r = $urandom % 4;
            cur_sel  = ($urandom % 8) != 0;
            cur.addr = {$urandom} & 32'hFFFF_FFF0;
            if (r == 0) begin
                cur.trans = 2'd0; cur.burst = 3'd0;
            end else if (r == 1) begin
                cur.trans = 2'd2; cur.burst = 3'd0;
            end else begin
                cur.trans  = 2'd2; cur.burst = 3'd3;
                next_addr  = cur.addr + 32'd4;
                beats_left = 3;
            end
        end
        if (cur_sel && cur.trans[1]) exp_q.push_back(cur);
    endtask

    task automatic drive_cur();
        HSELS = cur_sel; HADDRS = cur.addr; HTRANSS = cur.trans; HWRITES = cur.write;
        HSIZES = cur.size; HBURSTS = cur.burst; HPROTS = cur.prot; HMASTLOCKS = cur.lock;
    endtask

    task automatic drive_idle();
        HSELS = 1'b1; HADDRS = '0; HTRANSS = 2'd0; HWRITES = 1'b0;
        HSIZES = '0; HBURSTS = '0; HPROTS = '0; HMASTLOCKS = 1'b0;
    endtask

    // one model cycle: account for what the last edge did, then drive the next inputs
    task automatic model_cycle();
        @(posedge HCLK);
        if (sl_busy && s_rdy) sl_busy = 1'b0;
        else if (sl_busy && sl_left > 0) sl_left = sl_left - 1;
        if (s_acc) begin
            sl_busy = 1'b1;
            sl_err  = ($urandom % 5) == 0;
            sl_left = int'($urandom % 3) + (sl_err ? 1 : 0);
            resp_q.push_back(sl_err);
        end
        if (s_hready) begin
            m_dvalid = cur_sel & cur.trans[1];
            gen_next();
        end
        #1;
        drive_cur();
        active_in   = force_active ? 1'b1 : (($urandom % 3) != 0);
        readyout_in = sl_busy ? (sl_left == 0) : (($urandom % 4) != 0);
        resp_in     = sl_busy & sl_err & (sl_left <= 1);
        exp_err_low = sl_busy & sl_err & (sl_left == 1);
    endtask

    always @(negedge HCLK) begin
        xfer_t x;
        logic  r;
        s_acc    = sel_in & active_in & readyout_in;
        s_rdy    = readyout_in;
        s_hready = HREADYOUTS;
        if (model_on && HRESETn) begin
            if (s_acc) begin
                if (exp_q.size() == 0) fail("accept_without_issue");
                else begin
                    x = exp_q.pop_front();
                    chk("xfer_order", 64'(presented()), 64'(x));
                end
            end
            if (HREADYOUTS) begin
                if (m_dvalid) begin
                    if (resp_q.size() == 0) fail("done_before_accept");
                    else begin
                        r = resp_q.pop_front();
                        chk("data_resp", 64'(HRESPS), 64'(r));
                    end
                end else begin
                    chk("idle_resp", 64'(HRESPS), 64'd0);
                end
            end
            if (exp_err_low) chk("err_first_cycle", 64'({HRESPS, HREADYOUTS}), 64'b10);
            stall = HREADYOUTS ? 0 : stall + 1;
            if (stall == 64) fail("stall_timeout");
        end
    end

    initial begin
        model_on = 1'b0; gen_idle = 1'b0; force_active = 1'b0;
        sl_busy = 1'b0; sl_err = 1'b0; sl_left = 0; exp_err_low = 1'b0;
        m_dvalid = 1'b0; beats_left = 0; next_addr = '0; stall = 0;
        s_acc = 1'b0; s_rdy = 1'b0; s_hready = 1'b0;
        cur = '0; cur_sel = 1'b1;
        drive_idle();
        active_in = 1'b0; readyout_in = 1'b1; resp_in = 1'b0;
        HRESETn = 1'b0;
        #12;
        chk("rst_hreadyout", 64'(HREADYOUTS), 64'd1);
        chk("rst_hresp", 64'(HRESPS), 64'd0);
        chk("rst_sel", 64'(sel_in), 64'd0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        @(negedge HCLK);
        model_on = 1'b1;

        for (int i = 0; i < 3000; i++) model_cycle();
        gen_idle = 1'b1; force_active = 1'b1;
        for (int i = 0; i < 60; i++) model_cycle();
        @(negedge HCLK);
        chk("issue_queue_drained", 64'(exp_q.size()), 64'd0);
        chk("resp_queue_drained", 64'(resp_q.size()), 64'd0);
        model_on = 1'b0;

        // async reset mid-run, then a transfer accepted the cycle it is presented
        @(posedge HCLK); #1;
        drive_idle(); active_in = 1'b1; readyout_in = 1'b1; resp_in = 1'b0;
        HRESETn = 1'b0; #1;
        chk("rst2_hreadyout", 64'(HREADYOUTS), 64'd1);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        HTRANSS = 2'd2; HADDRS = 32'h1000; #1;
        chk("d1_sel_same_cycle", 64'(sel_in), 64'd1);
        chk("d1_addr_live", 64'(addr_in), 64'h1000);
        chk("d1_no_wait", 64'(HREADYOUTS), 64'd1);
        @(posedge HCLK); #1;
        drive_idle(); readyout_in = 1'b0; #1;
        chk("d1_dphase_wait", 64'(HREADYOUTS), 64'd0);
        readyout_in = 1'b1; #1;
        chk("d1_dphase_ready", 64'(HREADYOUTS), 64'd1);

        // IDLE and BUSY with the port selected get zero-wait OKAY
        @(posedge HCLK); #1;
        HTRANSS = 2'd1; resp_in = 1'b1; #1;
        chk("d3_busy_sel", 64'(sel_in), 64'd0);
        chk("d3_busy_resp", 64'({HREADYOUTS, HRESPS}), 64'b10);
        HTRANSS = 2'd0; #1;
        chk("d3_idle_sel", 64'(sel_in), 64'd0);
        resp_in = 1'b0;

        // two-cycle ERROR passes through
        HTRANSS = 2'd2; HADDRS = 32'h3000;
        @(posedge HCLK); #1;
        drive_idle(); readyout_in = 1'b0; resp_in = 1'b1; #1;
        chk("d4_err_cycle1", 64'({HRESPS, HREADYOUTS}), 64'b10);
        @(posedge HCLK); #1;
        readyout_in = 1'b1; #1;
        chk("d4_err_cycle2", 64'({HRESPS, HREADYOUTS}), 64'b11);
        @(posedge HCLK); #1;
        resp_in = 1'b0;

        // blocked transfer is held while the live address moves on
        HTRANSS = 2'd2; HADDRS = 32'h2000; active_in = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(posedge HCLK); #1;
            HADDRS = 32'h2000 + 32'(i * 32'h100); #1;
            chk("d2_wait", 64'(HREADYOUTS), 64'd0);
            chk("d2_addr_held", 64'({sel_in, addr_in}), {31'd0, 1'b1, 32'h2000});
        end
        active_in = 1'b1; HTRANSS = 2'd0;
        @(posedge HCLK); #1;
        chk("d2_pend_clear", 64'({HREADYOUTS, sel_in}), 64'b10);

        // reset while a transfer is held discards it
        HTRANSS = 2'd2; HADDRS = 32'h6000; active_in = 1'b0;
        @(posedge HCLK); #1;
        HTRANSS = 2'd0; #1;
        chk("d5_pending", 64'(HREADYOUTS), 64'd0);
        #2 HRESETn = 1'b0; #1;
        chk("d5_rst_async", 64'({HREADYOUTS, sel_in}), 64'b10);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        HTRANSS = 2'd2; HADDRS = 32'h7000; #1;
        chk("d5_live_after_rst", 64'({sel_in, addr_in}), {31'd0, 1'b1, 32'h7000});
        @(posedge HCLK); #1;
        drive_idle();
        @(posedge HCLK); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
